// File: rtl/glyph_writer_pkg.sv
// Shared frame-buffer geometry, command encodings and FSM state codes
// for the glyph writer and the display-side address logic.
package glyph_writer_pkg;

  localparam logic [15:0] FB_BASE            = 16'h3000;
  localparam int          SCREEN_WIDTH_WORDS = 40;
  localparam int          COLS               = 80;
  localparam int          ROWS               = 60;
  localparam int          FB_WORDS           = 2400;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_CLEAR = 1'b1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_CLR  = 3'd4;

endpackage

// File: rtl/fb_addr_calc.sv
// Character cell (row, col) to frame-buffer word address and byte select.
// Row stride of 40 words is built from shifts: 32*row + 8*row.
module fb_addr_calc #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] FB_BASE    = 16'h3000
) (
  input  logic [5:0]            row,
  input  logic [6:0]            col,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  lo_sel
);

  logic [ADDR_WIDTH-1:0] row_w;
  logic [ADDR_WIDTH-1:0] col_w;

  assign row_w  = ADDR_WIDTH'(row);
  assign col_w  = ADDR_WIDTH'(col[6:1]);
  assign addr   = FB_BASE + (row_w << 5) + (row_w << 3) + col_w;
  assign lo_sel = col[0];

endmodule

// File: rtl/glyph_writer.sv
// Text-mode frame-buffer writer: single-glyph read-modify-write
// and full-screen clear, one memory access per cycle.
module glyph_writer #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] FB_BASE    = 16'h3000,
  parameter int                    COLS       = 80,
  parameter int                    ROWS       = 60
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [6:0]            cmd_col,
  input  logic [5:0]            cmd_row,
  input  logic [7:0]            cmd_glyph,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata,
  output logic                  busy,
  output logic                  err
);

  import glyph_writer_pkg::*;

  logic [2:0]            state;
  logic [7:0]            glyph_q;
  logic                  lo_q;
  logic [11:0]           cnt;
  logic [ADDR_WIDTH-1:0] calc_addr;
  logic                  calc_lo;
  logic                  in_range;
  logic                  accept;

  fb_addr_calc #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .FB_BASE   (FB_BASE)
  ) u_addr (
    .row   (cmd_row),
    .col   (cmd_col),
    .addr  (calc_addr),
    .lo_sel(calc_lo)
  );

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign in_range  = (cmd_col < 7'(COLS)) && (cmd_row < 6'(ROWS));

  // Memory outputs are registered so each state presents its own access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      glyph_q   <= '0;
      lo_q      <= 1'b0;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (cmd_op == OP_CLEAR) begin
              state     <= S_CLR;
              cnt       <= '0;
              mem_addr  <= FB_BASE;
              mem_we    <= 1'b1;
              mem_wdata <= {cmd_glyph, cmd_glyph};
            end else if (in_range) begin
              state    <= S_RD;
              mem_addr <= calc_addr;
              glyph_q  <= cmd_glyph;
              lo_q     <= calc_lo;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_RD: state <= S_CAP;
        S_CAP: begin
          state     <= S_WR;
          mem_we    <= 1'b1;
          mem_wdata <= lo_q ? {mem_rdata[15:8], glyph_q}
                            : {glyph_q, mem_rdata[7:0]};
        end
        S_WR: begin
          state  <= S_IDLE;
          mem_we <= 1'b0;
        end
        S_CLR: begin
          if (cnt == 12'(FB_WORDS - 1)) begin
            state  <= S_IDLE;
            mem_we <= 1'b0;
          end else begin
            cnt      <= cnt + 12'd1;
            mem_addr <= FB_BASE + ADDR_WIDTH'(cnt + 12'd1);
          end
        end
        default: begin
          state  <= S_IDLE;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_glyph_writer.sv
// Self-checking bench for glyph_writer with a word-array frame-buffer
// model and a synchronous-read memory behind the DUT.
module tb_glyph_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [6:0]  cmd_col;
  logic [5:0]  cmd_row;
  logic [7:0]  cmd_glyph;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];

  glyph_writer dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_col  (cmd_col),
    .cmd_row  (cmd_row),
    .cmd_glyph(cmd_glyph),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic [6:0]  col;
    logic [5:0]  row;
    logic [7:0]  glyph;
    logic [15:0] pre;
    logic [15:0] exp_addr;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct {
    int          n_busy;
    int          n_we;
    int          n_err;
    logic [15:0] rd_addr;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        err1;
    logic        rdy1;
  } obs_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] cell_addr(input int c, input int r);
    return 16'(32'h3000 + r * 40 + c / 2);
  endfunction

  // Called at a negedge; returns just after the accepting posedge.
  task automatic issue(input logic op, input logic [6:0] c,
                       input logic [5:0] r, input logic [7:0] g);
    int t = 0;
    while (!cmd_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) chk("ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_col   = c;
    cmd_row   = r;
    cmd_glyph = g;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic observe(output obs_t o);
    bit done = 0;
    o = '{default: 0};
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) begin
        o.rd_addr = mem_addr;
        o.err1    = err;
        o.rdy1    = cmd_ready;
      end
      if (busy && !done) o.n_busy++;
      else done = 1;
      if (mem_we) begin
        o.n_we++;
        o.wr_addr = mem_addr;
        o.wr_data = mem_wdata;
      end
      if (err) o.n_err++;
    end
  endtask

  task automatic model_write(input int c, input int r, input logic [7:0] g,
                             output logic [15:0] a, output logic [15:0] d,
                             output bit inr);
    inr = (c < 80) && (r < 60);
    a   = cell_addr(c, r);
    d   = ref_mem[a];
    if (c % 2 == 0) d[15:8] = g;
    else d[7:0] = g;
    if (inr) ref_mem[a] = d;
  endtask

  vec_t vecs [9];
  obs_t o;

  initial begin
    vecs[0] = '{7'd0,   6'd0,  8'h41, 16'h1234, 16'h3000, 16'h4134, 1'b0};
    vecs[1] = '{7'd79,  6'd59, 8'h7F, 16'hAB00, 16'h395F, 16'hAB7F, 1'b0};
    vecs[2] = '{7'd80,  6'd3,  8'h11, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    vecs[3] = '{7'd1,   6'd0,  8'hAA, 16'h1234, 16'h3000, 16'h12AA, 1'b0};
    vecs[4] = '{7'd0,   6'd1,  8'h55, 16'hFFFF, 16'h3028, 16'h55FF, 1'b0};
    vecs[5] = '{7'd10,  6'd2,  8'h00, 16'hBEEF, 16'h3055, 16'h00EF, 1'b0};
    vecs[6] = '{7'd79,  6'd60, 8'h22, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    vecs[7] = '{7'd127, 6'd63, 8'h33, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    vecs[8] = '{7'd2,   6'd59, 8'hC3, 16'h0F0F, 16'h3939, 16'hC30F, 1'b0};

    for (int i = 0; i < 65536; i++) begin
      mem[i]     = (i >= 16'h3000 && i <= 16'h395F) ? 16'($urandom) : 16'h0;
      ref_mem[i] = mem[i];
    end

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_col   = '0;
    cmd_row   = '0;
    cmd_glyph = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_we",    32'(mem_we),    32'd0);
    chk("rst_err",   32'(err),       32'd0);
    chk("rst_addr",  32'(mem_addr),  32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      logic [15:0] a, d;
      bit inr;
      if (!vecs[i].exp_err) begin
        mem[vecs[i].exp_addr]     = vecs[i].pre;
        ref_mem[vecs[i].exp_addr] = vecs[i].pre;
      end
      model_write(int'(vecs[i].col), int'(vecs[i].row), vecs[i].glyph,
                  a, d, inr);
      issue(1'b0, vecs[i].col, vecs[i].row, vecs[i].glyph);
      observe(o);
      chk($sformatf("v%0d_busy", i), 32'(o.n_busy),
          vecs[i].exp_err ? 32'd0 : 32'd3);
      chk($sformatf("v%0d_we", i), 32'(o.n_we),
          vecs[i].exp_err ? 32'd0 : 32'd1);
      chk($sformatf("v%0d_err", i), 32'(o.n_err), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_err1", i), 32'(o.err1), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_rdy1", i), 32'(o.rdy1), 32'(vecs[i].exp_err));
      if (!vecs[i].exp_err) begin
        chk($sformatf("v%0d_rd_addr", i), 32'(o.rd_addr),
            32'(vecs[i].exp_addr));
        chk($sformatf("v%0d_wr_addr", i), 32'(o.wr_addr),
            32'(vecs[i].exp_addr));
        chk($sformatf("v%0d_wdata", i), 32'(o.wr_data),
            32'(vecs[i].exp_data));
      end
    end

    for (int n = 0; n < 40; n++) begin
      int c, r;
      logic [7:0]  g;
      logic [15:0] a, d;
      bit inr;
      c = int'($urandom_range(0, 85));
      r = int'($urandom_range(0, 63));
      g = 8'($urandom);
      model_write(c, r, g, a, d, inr);
      issue(1'b0, 7'(c), 6'(r), g);
      observe(o);
      chk($sformatf("r%0d_busy", n), 32'(o.n_busy), inr ? 32'd3 : 32'd0);
      chk($sformatf("r%0d_err", n), 32'(o.n_err), inr ? 32'd0 : 32'd1);
      if (inr) begin
        chk($sformatf("r%0d_addr", n), 32'(o.wr_addr), 32'(a));
        chk($sformatf("r%0d_wdata", n), 32'(o.wr_data), 32'(d));
      end else begin
        chk($sformatf("r%0d_we", n), 32'(o.n_we), 32'd0);
      end
    end

    // cmd_valid held through a whole write is taken again once idle.
    begin
      logic [15:0] a, d;
      logic [7:0]  we_mask = '0;
      bit inr;
      model_write(5, 7, 8'h3C, a, d, inr);
      cmd_valid = 1'b1;
      cmd_op    = 1'b0;
      cmd_col   = 7'd5;
      cmd_row   = 6'd7;
      cmd_glyph = 8'h3C;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        we_mask[i] = mem_we;
      end
      cmd_valid = 1'b0;
      chk("hold_we_pattern", 32'(we_mask), 32'h44);
      repeat (5) @(negedge clk);
    end

    // Full clear.
    begin
      int k = 0, t = 0, bad_we = 0, bad_addr = 0, bad_data = 0;
      issue(1'b1, 7'd0, 6'd0, 8'h20);
      @(negedge clk);
      while (busy && t < 3000) begin
        if (!mem_we) bad_we++;
        if (mem_addr !== 16'(32'h3000 + k)) bad_addr++;
        if (mem_wdata !== 16'h2020) bad_data++;
        k++;
        t++;
        @(negedge clk);
      end
      chk("clr_busy_cycles", 32'(k), 32'd2400);
      chk("clr_bad_we", 32'(bad_we), 32'd0);
      chk("clr_bad_addr", 32'(bad_addr), 32'd0);
      chk("clr_bad_data", 32'(bad_data), 32'd0);
      chk("clr_ready_after", 32'(cmd_ready), 32'd1);
      chk("clr_we_after", 32'(mem_we), 32'd0);
      for (int i = 16'h3000; i <= 16'h395F; i++) ref_mem[i] = 16'h2020;
    end

    // Reset in the middle of a clear.
    begin
      int n = 0, t = 0;
      logic [15:0] a, d;
      bit inr;
      issue(1'b1, 7'd0, 6'd0, 8'h55);
      while (n < 100 && t < 200) begin
        @(negedge clk);
        if (mem_we) n++;
        t++;
      end
      chk("rstclr_writes", 32'(n), 32'd100);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rstclr_we", 32'(mem_we), 32'd0);
      chk("rstclr_ready", 32'(cmd_ready), 32'd1);
      for (int i = 0; i < 100; i++) ref_mem[16'h3000 + i] = 16'h5555;
      model_write(3, 4, 8'h9A, a, d, inr);
      issue(1'b0, 7'd3, 6'd4, 8'h9A);
      observe(o);
      chk("post_rst_busy", 32'(o.n_busy), 32'd3);
      chk("post_rst_addr", 32'(o.wr_addr), 32'h30A1);
      chk("post_rst_wdata", 32'(o.wr_data), 32'(d));
    end

    begin
      int mism = 0;
      for (int i = 16'h3000; i <= 16'h395F; i++)
        if (mem[i] !== ref_mem[i]) mism++;
      chk("fb_contents", 32'(mism), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/glyph_writer.md
GLYPH_WRITER -- requirements
Module: glyph_writer

Interface
REQ-001 Parameter ADDR_WIDTH, 16, width of the memory address port.
REQ-002 Parameter FB_BASE, 16'h3000, word address of character cell (row 0, col 0).
REQ-003 Parameter COLS, 80, character columns per row (two 8-bit glyph codes per 16-bit word, 40 words per row).
REQ-004 Parameter ROWS, 60, character rows.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 cmd_valid  in  1  command request.
REQ-008 cmd_ready  out  1  block can accept a command; a transfer occurs when cmd_valid && cmd_ready at a rising edge.
REQ-009 cmd_op  in  1  0 = write one glyph, 1 = clear screen.
REQ-010 cmd_col  in  7  target column, 0..79 (ignored for clear).
REQ-011 cmd_row  in  6  target row, 0..59 (ignored for clear).
REQ-012 cmd_glyph  in  8  glyph code to write, or fill code for clear.
REQ-013 mem_addr  out  ADDR_WIDTH  frame-buffer word address.
REQ-014 mem_we  out  1  write enable for the current mem_addr.
REQ-015 mem_wdata  out  16  write data.
REQ-016 mem_rdata  in  16  read data; synchronous memory, valid the cycle after mem_addr is sampled.
REQ-017 busy  out  1  high whenever the state is not IDLE.
REQ-018 err  out  1  one-cycle pulse on an accepted out-of-range write.

Function
REQ-019 FSM states: IDLE, RD, CAP, WR, CLR; cmd_ready = (state == IDLE).
REQ-020 Word address = FB_BASE + 40*row + col[6:1], computed as (row<<5)+(row<<3) with no multiplier; col[0]=0 selects bits [15:8], col[0]=1 selects bits [7:0].
REQ-021 Glyph write accepted in IDLE with col<80 and row<60: IDLE->RD; command fields registered at acceptance.
REQ-022 RD: mem_addr = word address, mem_we=0; next state CAP.
REQ-023 CAP: mem_rdata captured at end of cycle; next state WR.
REQ-024 WR: mem_we=1, same mem_addr, mem_wdata = captured word with the selected byte replaced by the glyph and the other byte unchanged; next state IDLE.
REQ-025 Glyph-write latency: exactly 3 busy cycles (RD, CAP, WR); cmd_ready high again on the 4th cycle after acceptance.
REQ-026 Out-of-range write (col>=80 or row>=60): accepted, no memory access, err=1 for the following cycle, state remains IDLE.
REQ-027 Clear accepted in IDLE: IDLE->CLR; word counter starts at 0.
REQ-028 CLR: one write per cycle, mem_we=1, mem_addr = FB_BASE + counter, mem_wdata = {glyph, glyph}; counter increments 0..2399; after the write at 2399, next state IDLE.
REQ-029 Clear duration: exactly 2400 busy cycles, covering 16'h3000..16'h395F.
REQ-030 Commands presented while busy are not accepted; cmd_valid may stay asserted and is taken in IDLE.
REQ-031 mem_we is low in IDLE, RD and CAP; mem_addr holds its last value in IDLE.

Reset
REQ-032 Reset outputs: state IDLE, cmd_ready=1, busy=0, err=0, mem_we=0, mem_addr=0, mem_wdata=0, counter=0.
REQ-033 Reset has priority over every state; reset during RD/CAP/WR/CLR aborts the operation and drives mem_we=0 from the next cycle. A partial clear is left as written.

Structure
REQ-034 Shared package holds FB_BASE, SCREEN_WIDTH_WORDS=40, COLS, ROWS, FB_WORDS=2400, the cmd_op encodings, and the state encoding.
REQ-035 One combinational sub-module, fb_addr_calc, maps (row, col) to the word address and the byte-select bit; the same mapping is reused by the display-side address logic.

Verification
REQ-036 Reset for 2 cycles -> cmd_ready=1, busy=0, mem_we=0, err=0.
REQ-037 Write col=0, row=0, glyph=8'h41, mem_rdata=16'h1234 in CAP -> RD addr 16'h3000; WR addr 16'h3000, mem_wdata=16'h4134; ready after 3 busy cycles.
REQ-038 Write col=79, row=59, glyph=8'h7F, mem_rdata=16'hAB00 -> addr 16'h395F, mem_wdata=16'hAB7F.
REQ-039 Clear with glyph=8'h20 -> 2400 consecutive writes, addresses 16'h3000..16'h395F, data 16'h2020; busy for 2400 cycles; cmd_ready asserted on the cycle after the last write.
REQ-040 Write col=80, row=3 -> err high for exactly 1 cycle; mem_we never asserted; cmd_ready stays 1.
REQ-041 Reset asserted after the 100th clear write -> mem_we=0 and cmd_ready=1 on the following cycle; a new glyph write then completes normally.
